// File: rtl/fetch_pc_unit.sv
// Program counter, next-PC selection and a circular return-address stack.
// fetch_addr is combinational from the redirect inputs; pc and the RAS pulses are registered one cycle later.
module fetch_pc_unit #(
  parameter int              ADDR_W    = 10,
  parameter int              OFF_W     = 16,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_stall,
  input  logic                         i_branch_taken,
  input  logic [OFF_W-1:0]             i_branch_off,
  input  logic                         i_jump,
  input  logic [ADDR_W-1:0]            i_jump_target,
  input  logic                         i_jr,
  input  logic [ADDR_W-1:0]            i_jr_target,
  input  logic                         i_jal,
  output logic [ADDR_W-1:0]            o_pc,
  output logic [ADDR_W-1:0]            o_pc_plus1,
  output logic [ADDR_W-1:0]            o_fetch_addr,
  output logic [ADDR_W-1:0]            o_ras_top,
  output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
  output logic                         o_ras_mispredict,
  output logic                         o_ras_overflow,
  output logic                         o_ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = (OFF_W > ADDR_W) ? OFF_W : ADDR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]     r_ptr;
  logic [CW-1:0]     r_count;
  logic              r_mis;
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W-1:0] w_pc_plus1;
  logic [EW-1:0]     w_off_ext;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [PW-1:0]     w_top_idx;
  logic [ADDR_W-1:0] w_top;
  logic              w_nonempty;
  logic              w_full;
  logic              w_ras_en;

  assign w_pc_plus1  = r_pc + ADDR_W'(1);
  assign w_off_ext   = EW'($signed(i_branch_off));
  assign w_br_target = w_pc_plus1 + w_off_ext[ADDR_W-1:0];

  always_comb begin
    w_fetch_addr = w_pc_plus1;
    if (i_rst)               w_fetch_addr = RESET_PC;
    else if (i_stall)        w_fetch_addr = r_pc;
    else if (i_jr)           w_fetch_addr = i_jr_target;
    else if (i_jump)         w_fetch_addr = i_jump_target;
    else if (i_branch_taken) w_fetch_addr = w_br_target;
  end

  assign w_top_idx  = r_ptr - PW'(1);
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(RAS_DEPTH));
  assign w_top      = w_nonempty ? r_stack[w_top_idx] : '0;
  assign w_ras_en   = !i_rst && !i_stall;

  // fetch_addr already resolves to RESET_PC under reset, so pc needs no separate reset branch.
  always_ff @(posedge i_clk) begin
    r_pc <= w_fetch_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_mis   <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_mis <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (w_ras_en) begin
        if (i_jal && i_jr && w_nonempty) begin
          // Pop-then-push collapses to replacing the top entry in place.
          r_stack[w_top_idx] <= w_pc_plus1;
          r_mis              <= (w_top != i_jr_target);
        end else if (i_jal) begin
          r_stack[r_ptr] <= w_pc_plus1;
          r_ptr          <= r_ptr + PW'(1);
          if (w_full) r_ovf   <= 1'b1;
          else        r_count <= r_count + CW'(1);
          if (i_jr) begin
            r_unf <= 1'b1;
            r_mis <= 1'b1;
          end
        end else if (i_jr) begin
          if (w_nonempty) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - CW'(1);
            r_mis   <= (w_top != i_jr_target);
          end else begin
            r_unf <= 1'b1;
            r_mis <= 1'b1;
          end
        end
      end
    end
  end

  assign o_pc             = r_pc;
  assign o_pc_plus1       = w_pc_plus1;
  assign o_fetch_addr     = w_fetch_addr;
  assign o_ras_top        = w_top;
  assign o_ras_count      = r_count;
  assign o_ras_mispredict = r_mis;
  assign o_ras_overflow   = r_ovf;
  assign o_ras_underflow  = r_unf;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomised and directed bench for fetch_pc_unit against a queue-based PC/RAS model.
module tb_fetch_pc_unit;

  localparam int AW    = 10;
  localparam int OW    = 16;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, stall, branch_taken, jump, jr, jal;
  logic [OW-1:0] branch_off;
  logic [AW-1:0] jump_target, jr_target;
  logic [AW-1:0] pc, pc_plus1, fetch_addr, ras_top;
  logic [$clog2(DEPTH):0] ras_count;
  logic          ras_mis, ras_ovf, ras_unf;

  int n_tests = 0;
  int n_fail  = 0;

  int m_pc = 0;
  int m_ras[$];
  int m_mis = 0, m_ovf = 0, m_unf = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_W(AW), .OFF_W(OW), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_branch_taken(branch_taken), .i_branch_off(branch_off),
    .i_jump(jump), .i_jump_target(jump_target),
    .i_jr(jr), .i_jr_target(jr_target), .i_jal(jal),
    .o_pc(pc), .o_pc_plus1(pc_plus1), .o_fetch_addr(fetch_addr),
    .o_ras_top(ras_top), .o_ras_count(ras_count),
    .o_ras_mispredict(ras_mis), .o_ras_overflow(ras_ovf), .o_ras_underflow(ras_unf)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_fetch();
    int pc1 = (m_pc + 1) % MOD;
    int off = int'($signed(branch_off));
    if (rst)          return 0;
    if (stall)        return m_pc;
    if (jr)           return int'(jr_target);
    if (jump)         return int'(jump_target);
    if (branch_taken) return (((pc1 + off) % MOD) + MOD) % MOD;
    return pc1;
  endfunction

  task automatic idle_inputs();
    rst = 0; stall = 0; branch_taken = 0; branch_off = '0;
    jump = 0; jump_target = '0; jr = 0; jr_target = '0; jal = 0;
  endtask

  // Inputs are already driven (after a negedge); check combinational path, clock, check state.
  task automatic cycle();
    int exp_fa  = model_fetch();
    int pc1     = (m_pc + 1) % MOD;
    #1;
    check_eq("fetch_addr", int'(fetch_addr), exp_fa);
    if (!rst) check_eq("pc_plus1", int'(pc_plus1), pc1);
    @(posedge clk);
    m_mis = 0; m_ovf = 0; m_unf = 0;
    if (rst) begin
      m_ras.delete();
    end else if (!stall) begin
      if (jal && jr) begin
        if (m_ras.size() > 0) begin
          m_mis = (m_ras[$] != int'(jr_target));
          m_ras[m_ras.size()-1] = pc1;
        end else begin
          m_unf = 1; m_mis = 1;
          m_ras.push_back(pc1);
        end
      end else if (jal) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(pc1);
      end else if (jr) begin
        if (m_ras.size() > 0) begin
          m_mis = (m_ras[$] != int'(jr_target));
          void'(m_ras.pop_back());
        end else begin
          m_unf = 1; m_mis = 1;
        end
      end
    end
    m_pc = exp_fa;
    #1;
    check_eq("pc", int'(pc), m_pc);
    check_eq("ras_count", int'(ras_count), m_ras.size());
    check_eq("ras_top", int'(ras_top), (m_ras.size() > 0) ? m_ras[$] : 0);
    check_eq("ras_mispredict", int'(ras_mis), m_mis);
    check_eq("ras_overflow", int'(ras_ovf), m_ovf);
    check_eq("ras_underflow", int'(ras_unf), m_unf);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic goto_pc(input int target);
    jump = 1; jump_target = AW'(target);
    cycle();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);

    // Reset then free-run
    rst = 1; cycle();
    rst = 1; cycle();
    check_eq("reset_pc", int'(pc), 0);
    check_eq("reset_count", int'(ras_count), 0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check_eq("freerun_pc", int'(pc), i);
    end
    goto_pc(1022);
    cycle();
    check_eq("pc_1023", int'(pc), 1023);
    cycle();
    check_eq("pc_wrap", int'(pc), 0);

    // Branches from pc=20
    goto_pc(20);
    branch_taken = 1; branch_off = 16'hFFFA; cycle();
    check_eq("branch_neg", int'(pc), 15);
    goto_pc(20);
    branch_taken = 1; branch_off = 16'd5; cycle();
    check_eq("branch_pos", int'(pc), 26);
    goto_pc(20);
    branch_taken = 1; branch_off = 16'd5; jump = 1; jump_target = 10'd100; cycle();
    check_eq("jump_over_branch", int'(pc), 100);
    goto_pc(1023);
    branch_taken = 1; branch_off = 16'd3; cycle();
    check_eq("branch_wrap", int'(pc), 3);

    // Priority and stall from pc=40
    goto_pc(40);
    stall = 1; jr = 1; jr_target = 10'd7; jump = 1; jump_target = 10'd9; jal = 1;
    cycle();
    check_eq("stall_pc", int'(pc), 40);
    jr = 1; jr_target = 10'd7; jump = 1; jump_target = 10'd9; cycle();
    check_eq("jr_over_jump", int'(pc), 7);

    // Call / return from pc=50
    goto_pc(50);
    jal = 1; jump = 1; jump_target = 10'd200; cycle();
    check_eq("call_pc", int'(pc), 200);
    check_eq("call_top", int'(ras_top), 51);
    jr = 1; jr_target = 10'd51; cycle();
    check_eq("ret_pc", int'(pc), 51);
    check_eq("ret_mis", int'(ras_mis), 0);
    goto_pc(50);
    jal = 1; jump = 1; jump_target = 10'd200; cycle();
    jr = 1; jr_target = 10'd52; cycle();
    check_eq("ret_mis_pulse", int'(ras_mis), 1);
    cycle();
    check_eq("ret_mis_clear", int'(ras_mis), 0);

    // Overflow then underflow
    goto_pc(10);
    for (int i = 0; i < 5; i++) begin
      jal = 1; cycle();
    end
    check_eq("ovf_pulse", int'(ras_ovf), 1);
    check_eq("ovf_count", int'(ras_count), DEPTH);
    check_eq("ovf_top", int'(ras_top), 15);
    for (int i = 0; i < 5; i++) begin
      jr = 1; jr_target = AW'($urandom_range(0, MOD - 1)); cycle();
    end
    check_eq("unf_pulse", int'(ras_unf), 1);
    check_eq("unf_mis", int'(ras_mis), 1);
    check_eq("unf_top", int'(ras_top), 0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      jal = 1; cycle();
    end
    check_eq("pre_rst_count", int'(ras_count), 3);
    jal = 1; stall = 1; rst = 1; cycle();
    check_eq("mid_rst_pc", int'(pc), 0);
    check_eq("mid_rst_count", int'(ras_count), 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 49) == 0);
      stall        = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      branch_off   = OW'($urandom);
      jump         = ($urandom_range(0, 5) == 0);
      jump_target  = AW'($urandom);
      jr           = ($urandom_range(0, 4) == 0);
      jal          = ($urandom_range(0, 3) == 0);
      jr_target    = (m_ras.size() > 0 && $urandom_range(0, 1) == 1) ? AW'(m_ras[$]) : AW'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Parametrised program-counter and next-PC block for the next processor generation.
- Replaces the fixed 10-bit PC register, the +1 adder and the branch/jump/jr mux chain with a single sequential unit.
- Adds stall, flush-safe redirect priority, a configurable address width, and a return-address stack (RAS) that tracks jal/jr pairs and flags jr mispredictions.
- Sits between the control unit/register file and the synchronous instruction memory, which is addressed with fetch_addr (next PC).

Parameters:
- ADDR_W, 10: PC and address width in words.
- OFF_W, 16: branch offset width, two's complement.
- RAS_DEPTH, 8: return-address stack entries, power of two, at least 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC and the RAS; refetch the current PC.
- branch_taken  in  1  conditional branch resolved taken (Branch & (bne ^ zero) computed upstream).
- branch_off  in  OFF_W  branch offset relative to pc_plus1.
- jump  in  1  unconditional jump (j/jal).
- jump_target  in  ADDR_W  absolute jump target.
- jr  in  1  jump-register.
- jr_target  in  ADDR_W  register value for jr.
- jal  in  1  link: push pc_plus1 onto the RAS.
- pc  out  ADDR_W  current PC (registered).
- pc_plus1  out  ADDR_W  pc+1, wraps modulo 2^ADDR_W (combinational).
- fetch_addr  out  ADDR_W  next PC, fed to the instruction-memory address (combinational).
- ras_top  out  ADDR_W  current RAS top; 0 when empty.
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid entries.
- ras_mispredict  out  1  registered one-cycle pulse.
- ras_overflow  out  1  registered one-cycle pulse.
- ras_underflow  out  1  registered one-cycle pulse.

Behaviour:
- Reset (rst=1 on an edge):
  - pc=RESET_PC, ras_count=0, RAS pointer=0, all pulses=0.
  - While rst=1, fetch_addr=RESET_PC.
  - rst overrides every other input, including a mid-stall or mid-redirect state.
- fetch_addr priority (combinational): rst > stall > jr > jump > branch_taken > sequential.
  - rst: RESET_PC.
  - stall: pc.
  - jr: jr_target.
  - jump: jump_target.
  - branch_taken: pc_plus1 + sign_extend(branch_off), truncated to ADDR_W bits (wraps).
  - Otherwise: pc_plus1.
- pc <= fetch_addr on every non-reset edge. Latency is zero cycles from redirect inputs to fetch_addr and one cycle to pc.
- RAS operations occur only on edges with rst=0 and stall=0:
  - jal alone: push pc_plus1. If full, the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, and ras_overflow pulses.
  - jr alone with ras_count>0: pop. ras_mispredict pulses if ras_top != jr_target.
  - jr alone with ras_count=0: no pointer change; ras_underflow and ras_mispredict both pulse.
  - jal and jr together: pop then push in the same edge, so the top entry is replaced by pc_plus1 and the count is unchanged. If count was 0, this is a push with an underflow pulse. The mispredict check uses the pre-edge top.
- The jump, branch and jr inputs do not alter the RAS except as listed above.
- All pulses are high for exactly one cycle following the causing edge, then clear unless re-triggered.
- Stall blocks pushes and pops, and the pulses read 0 in the following cycle.
- ras_top is combinational from the stack at pointer-1, and is 0 when ras_count=0.
- Address wrap: pc = 2^ADDR_W-1 sequential gives pc_plus1 = 0. Negative branch offsets wrap the same way.

Test Plan:
- Reset then free-run (ADDR_W=10): rst=1 for 2 cycles, then idle.
  - Required: pc sequence 0,1,2,3.
  - Required: fetch_addr leads pc by one.
  - Required: pc=1023 is followed by pc=0.
- Branch (pc=20):
  - branch_off=0xFFFA (−6) → next pc=15.
  - branch_off=5 → next pc=26.
  - With both jump=1 (jump_target=100) and branch_taken=1 → pc=100.
- Priority and stall (pc=40, jr=1, jr_target=7, jump=1, jump_target=9, stall=1):
  - Required: pc stays 40.
  - Required: fetch_addr=40.
  - Required: RAS unchanged.
  - After dropping stall → pc=7.
- Call/return (pc=50):
  - jal+jump to 200 → pc=200, ras_top=51, ras_count=1.
  - jr with jr_target=51 → pc=51, ras_count=0, no mispredict.
  - jr with jr_target=52 instead → ras_mispredict pulses for one cycle.
- Overflow/underflow (RAS_DEPTH=4):
  - 5 consecutive jal pushes at pcs 10..14 → ras_overflow pulse on the 5th, ras_count=4, ras_top=15.
  - 4 pops then a 5th jr → ras_underflow and ras_mispredict pulse, ras_count=0, ras_top=0.
- Reset mid-operation: ras_count=3 and a jal pending, assert rst → next cycle pc=RESET_PC, ras_count=0, all pulses 0.
